// File: rtl/lsu_mem_master.sv
// Load/store initiator: checks each request for legality, alignment and range, then
// issues one single-cycle access to a byte-addressable memory and holds the response.
module lsu_mem_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_illegal,
  output logic                  resp_fault,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [3:0]            mem_write_byte_enable,
  output logic [2:0]            mem_load_type,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] MEM_LIMIT = AW1'(MEM_SIZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;

  logic           illegal_c;
  logic           misaligned_c;
  logic           fault_c;
  logic [1:0]     span_c;
  logic [AW1-1:0] last_c;
  logic [3:0]     be_c;

  // Request decode; extra address bit keeps the last-byte sum from wrapping.
  always_comb begin
    illegal_c    = 1'b0;
    misaligned_c = 1'b0;
    fault_c      = 1'b0;
    span_c       = 2'd0;
    be_c         = 4'b0001;
    case (req_funct3[1:0])
      2'b00:   begin span_c = 2'd0; be_c = 4'b0001; end
      2'b01:   begin span_c = 2'd1; be_c = 4'b0011; end
      default: begin span_c = 2'd3; be_c = 4'b1111; end
    endcase
    last_c = {1'b0, req_addr} + AW1'(span_c);
    if (req_we) illegal_c = (req_funct3 > 3'b010);
    else        illegal_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    if (!illegal_c) begin
      misaligned_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      fault_c      = !misaligned_c && (last_c >= MEM_LIMIT);
    end
  end

  assign req_ready = (state == IDLE);

  // Control FSM with all memory and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      resp_valid            <= 1'b0;
      resp_rdata            <= '0;
      resp_misaligned       <= 1'b0;
      resp_illegal          <= 1'b0;
      resp_fault            <= 1'b0;
      mem_wr_en             <= 1'b0;
      mem_rd_en             <= 1'b0;
      mem_write_byte_enable <= 4'b0000;
      mem_load_type         <= 3'b000;
      mem_addr              <= '0;
      mem_wr_data           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr        <= req_addr;
            mem_wr_data     <= req_wdata;
            mem_load_type   <= req_funct3;
            resp_rdata      <= '0;
            resp_illegal    <= illegal_c;
            resp_misaligned <= misaligned_c;
            resp_fault      <= fault_c;
            if (illegal_c || misaligned_c || fault_c) begin
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              mem_wr_en             <= req_we;
              mem_rd_en             <= !req_we;
              mem_write_byte_enable <= req_we ? be_c : 4'b0000;
              state                 <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_rd_en) resp_rdata <= mem_rd_data;
          mem_wr_en             <= 1'b0;
          mem_rd_en             <= 1'b0;
          mem_write_byte_enable <= 4'b0000;
          resp_valid            <= 1'b1;
          state                 <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small byte-addressable memory model.
module tb_lsu_mem_master;

  localparam int unsigned MEM_SIZE = 1048576;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic        resp_fault;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [3:0]  mem_write_byte_enable;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_we                (req_we),
    .req_funct3            (req_funct3),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .resp_valid            (resp_valid),
    .resp_ready            (resp_ready),
    .resp_rdata            (resp_rdata),
    .resp_misaligned       (resp_misaligned),
    .resp_illegal          (resp_illegal),
    .resp_fault            (resp_fault),
    .mem_wr_en             (mem_wr_en),
    .mem_rd_en             (mem_rd_en),
    .mem_write_byte_enable (mem_write_byte_enable),
    .mem_load_type         (mem_load_type),
    .mem_addr              (mem_addr),
    .mem_wr_data           (mem_wr_data),
    .mem_rd_data           (mem_rd_data)
  );

  always #5 clk = ~clk;

  // Memory model: 256 bytes aliased on addr[7:0], extension done on the read side.
  logic [7:0] mem [256];
  logic [7:0] b0, b1, b2, b3;

  always @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_byte_enable[i]) mem[mem_addr[7:0] + 8'(i)] <= mem_wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    b0 = mem[mem_addr[7:0]];
    b1 = mem[mem_addr[7:0] + 8'd1];
    b2 = mem[mem_addr[7:0] + 8'd2];
    b3 = mem[mem_addr[7:0] + 8'd3];
    case (mem_load_type)
      3'b000:  mem_rd_data = {{24{b0[7]}}, b0};
      3'b001:  mem_rd_data = {{16{b1[7]}}, b1, b0};
      3'b100:  mem_rd_data = {24'd0, b0};
      3'b101:  mem_rd_data = {16'd0, b1, b0};
      default: mem_rd_data = {b3, b2, b1, b0};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request at the falling edge; it is taken at the next rising edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Full operation with resp_ready high; exp_flags = {illegal, misaligned, fault}.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] exp_flags, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_be);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    issue(we, f3, a, wd);
    if (exp_flags == 3'b000) begin
      check({tag, "_wr_en"}, 32'(mem_wr_en), 32'(we));
      check({tag, "_rd_en"}, 32'(mem_rd_en), 32'(!we));
      check({tag, "_be"}, 32'(mem_write_byte_enable), 32'(exp_be));
      check({tag, "_addr"}, mem_addr, a);
      check({tag, "_early_valid"}, 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
    end else begin
      check({tag, "_no_access"}, 32'({mem_wr_en, mem_rd_en}), 32'd0);
    end
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_flags"}, 32'({resp_illegal, resp_misaligned, resp_fault}), 32'(exp_flags));
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done"}, 32'({resp_valid, mem_wr_en, mem_rd_en}), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_en", 32'({mem_wr_en, mem_rd_en}), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    run_op("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3'b000, 32'h0, 4'b1111);
    run_op("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 3'b000, 32'hDEADBEEF, 4'b0000);
    run_op("sb_21", 1'b1, 3'b000, 32'h21, 32'h000000F0, 3'b000, 32'h0, 4'b0001);
    run_op("lb_21", 1'b0, 3'b000, 32'h21, 32'h0, 3'b000, 32'hFFFFFFF0, 4'b0000);
    run_op("lbu_21", 1'b0, 3'b100, 32'h21, 32'h0, 3'b000, 32'h000000F0, 4'b0000);
    run_op("lh_10", 1'b0, 3'b001, 32'h10, 32'h0, 3'b000, 32'hFFFFBEEF, 4'b0000);
    run_op("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 3'b000, 32'h0000DEAD, 4'b0000);
    run_op("lh_3", 1'b0, 3'b001, 32'h3, 32'h0, 3'b010, 32'h0, 4'b0000);
    run_op("sw_6", 1'b1, 3'b010, 32'h6, 32'h11223344, 3'b010, 32'h0, 4'b0000);
    run_op("ld_011", 1'b0, 3'b011, 32'h10, 32'h0, 3'b100, 32'h0, 4'b0000);
    run_op("st_100", 1'b1, 3'b100, 32'h10, 32'h0, 3'b100, 32'h0, 4'b0000);
    run_op("lw_top", 1'b0, 3'b010, MEM_SIZE - 4, 32'h0, 3'b000, 32'h0, 4'b0000);
    // misaligned outranks fault at MEM_SIZE-2
    run_op("lw_top2", 1'b0, 3'b010, MEM_SIZE - 2, 32'h0, 3'b010, 32'h0, 4'b0000);
    run_op("lw_end", 1'b0, 3'b010, MEM_SIZE, 32'h0, 3'b001, 32'h0, 4'b0000);
    run_op("sh_end", 1'b1, 3'b001, MEM_SIZE - 1, 32'h0, 3'b010, 32'h0, 4'b0000);
    run_op("lh_end", 1'b0, 3'b001, MEM_SIZE - 2, 32'h0, 3'b000, 32'h0, 4'b0000);
    run_op("sb_end", 1'b1, 3'b000, MEM_SIZE, 32'h5A, 3'b001, 32'h0, 4'b0000);

    // Response backpressure with a competing request held by the sender.
    resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h40;
    req_wdata  = 32'h0000005A;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_no_access", 32'({mem_wr_en, mem_rd_en}), 32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", 32'({resp_valid, mem_wr_en, req_ready}), 32'b001);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_sb_wr", 32'({mem_wr_en, mem_write_byte_enable}), 32'b10001);
    check("bp_sb_addr", mem_addr, 32'h40);
    @(posedge clk);
    #1;
    check("bp_sb_resp", 32'({resp_valid, resp_fault, resp_misaligned, resp_illegal}), 32'b1000);
    @(posedge clk);
    #1;
    run_op("lbu_40", 1'b0, 3'b100, 32'h40, 32'h0, 3'b000, 32'h0000005A, 4'b0000);

    // Reset during the access cycle of a store must suppress the write.
    issue(1'b1, 3'b010, 32'h30, 32'h12345678);
    check("rs_wr_pre", 32'(mem_wr_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs_wr", 32'({mem_wr_en, mem_rd_en}), 32'd0);
    check("rs_be", 32'(mem_write_byte_enable), 32'd0);
    check("rs_addr", mem_addr, 32'd0);
    check("rs_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rs_ready", 32'(req_ready), 32'd1);
    run_op("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 3'b000, 32'h0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
